// File: rtl/nibble_collect_if.sv
// Nibble-in / word-out bus for nibble_collect.
// master drives nibbles and ready; slave returns the FIFO head.
interface nibble_collect_if;
  logic [3:0]  din;
  logic        din_vld;
  logic        word_rdy;
  logic [15:0] word;
  logic        word_vld;
  logic [2:0]  level;
  logic        ovf;
  logic        tmo;

  modport master (
    output din,
    output din_vld,
    output word_rdy,
    input  word,
    input  word_vld,
    input  level,
    input  ovf,
    input  tmo
  );

  modport slave (
    input  din,
    input  din_vld,
    input  word_rdy,
    output word,
    output word_vld,
    output level,
    output ovf,
    output tmo
  );
endinterface

// File: rtl/nibble_collect.sv
// Packs 4-bit nibbles MSB-first into 16-bit words behind a 4-deep FIFO.
// Optional partial-word timeout: define NIBBLE_TIMEOUT_EN.
module nibble_collect (
  input logic             clk,
  input logic             rst,
  nibble_collect_if.slave bus
);

  logic [1:0]  cnt;
  logic [11:0] part;
  logic [15:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  lvl;
  logic        ovf_q;
  logic        tmo_q;
  logic        tmo_hit;

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        wr_en;
  logic        drop;
  logic [15:0] new_word;

  // FIFO status and push/pop qualification
  always_comb begin
    empty    = (lvl == 3'd0);
    full     = (lvl == 3'd4);
    push     = bus.din_vld && (cnt == 2'd3);
    pop      = !empty && bus.word_rdy;
    wr_en    = push && (!full || pop);
    drop     = push && full && !pop;
    new_word = {part, bus.din};
  end

`ifdef NIBBLE_TIMEOUT_EN
  logic [3:0] idle;

  // 8th idle cycle of a started word discards it
  always_comb begin
    tmo_hit = !bus.din_vld && (cnt != 2'd0)
              && (idle == 4'd7);
  end

  // idle counter and one-cycle timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      idle  <= 4'd0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (bus.din_vld || tmo_hit) begin
        idle <= 4'd0;
      end else if (cnt != 2'd0) begin
        idle <= idle + 4'd1;
      end
    end
  end
`else
  // partial words are held indefinitely
  always_comb begin
    tmo_hit = 1'b0;
    tmo_q   = 1'b0;
  end
`endif

  // nibble counter and partial word assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      part <= 12'h000;
    end else if (tmo_hit) begin
      cnt  <= 2'd0;
      part <= 12'h000;
    end else if (bus.din_vld) begin
      cnt <= cnt + 2'd1;
      unique case (cnt)
        2'd0: part[11:8] <= bus.din;
        2'd1: part[7:4]  <= bus.din;
        2'd2: part[3:0]  <= bus.din;
        2'd3: part       <= 12'h000;
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are masked while empty
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= new_word;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      lvl    <= 3'd0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (wr_en && !pop) begin
        lvl <= lvl + 3'd1;
      end else if (pop && !wr_en) begin
        lvl <= lvl - 3'd1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // head of FIFO and status to the bus
  always_comb begin
    bus.word     = empty ? 16'h0000 : mem[rd_ptr];
    bus.word_vld = !empty;
    bus.level    = lvl;
    bus.ovf      = ovf_q;
    bus.tmo      = tmo_q;
  end

endmodule

// File: tb/tb_nibble_collect.sv
// Directed and random checks of nibble_collect against a queue model.
// Build with +define+NIBBLE_TIMEOUT_EN to exercise the timeout path.
module tb_nibble_collect;

  logic clk = 1'b0;
  logic rst = 1'b0;

  nibble_collect_if bus ();

  nibble_collect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  logic [15:0] q    [$];
  logic [3:0]  nibs [$];
  int          idle_n = 0;
  logic        m_ovf  = 1'b0;
  logic        m_tmo  = 1'b0;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_head();
    return (q.size() > 0) ? q[0] : 16'h0000;
  endfunction

  // model reaction to one clock edge with given inputs
  task automatic model_edge(input logic [3:0] d,
                            input logic v,
                            input logic r,
                            input logic rs);
    logic [15:0] w;
    if (rs) begin
      q.delete();
      nibs.delete();
      idle_n = 0;
      m_ovf  = 1'b0;
      m_tmo  = 1'b0;
      return;
    end
    m_tmo = 1'b0;
    if (q.size() > 0 && r) void'(q.pop_front());
    if (v) begin
      idle_n = 0;
      nibs.push_back(d);
      if (nibs.size() == 4) begin
        w = {nibs[0], nibs[1], nibs[2], nibs[3]};
        nibs.delete();
        if (q.size() < 4) q.push_back(w);
        else m_ovf = 1'b1;
      end
    end else if (nibs.size() > 0) begin
`ifdef NIBBLE_TIMEOUT_EN
      idle_n++;
      if (idle_n == 8) begin
        nibs.delete();
        idle_n = 0;
        m_tmo  = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_all();
    chk("word",  bus.word, m_head());
    chk("vld",   16'(bus.word_vld), 16'(q.size() > 0));
    chk("level", 16'(bus.level), 16'(q.size()));
    chk("ovf",   16'(bus.ovf), 16'(m_ovf));
    chk("tmo",   16'(bus.tmo), 16'(m_tmo));
  endtask

  // one clock: drive, edge, model, sample on falling edge
  task automatic step(input logic [3:0] d,
                      input logic v,
                      input logic r,
                      input logic rs = 1'b0);
    bus.din      = d;
    bus.din_vld  = v;
    bus.word_rdy = r;
    rst          = rs;
    @(posedge clk);
    model_edge(d, v, r, rs);
    @(negedge clk);
    check_all();
  endtask

  task automatic send_word(input logic [15:0] w,
                           input logic r);
    for (int i = 3; i >= 0; i--) begin
      step(4'((w >> (4 * i)) & 16'hF), 1'b1, r);
    end
  endtask

  initial begin
    bus.din      = 4'h0;
    bus.din_vld  = 1'b0;
    bus.word_rdy = 1'b0;
    @(negedge clk);

    // reset, then 1,2,3,4 back to back
    step(4'h5, 1'b1, 1'b1, 1'b1);
    chk("rst_word", bus.word, 16'h0000);
    chk("rst_lvl",  16'(bus.level), 16'h0);
    send_word(16'h1234, 1'b1);
    chk("w1234", bus.word, 16'h1234);
    chk("v1234", 16'(bus.word_vld), 16'h1);
    step(4'h0, 1'b0, 1'b1);
    chk("pop_lvl0", 16'(bus.level), 16'h0);

    // overflow with ready low
    for (int k = 1; k <= 5; k++) begin
      send_word(16'hA000 + 16'(k), 1'b0);
    end
    chk("ovf_lvl",  16'(bus.level), 16'h4);
    chk("ovf_flag", 16'(bus.ovf), 16'h1);
    chk("ovf_head", bus.word, 16'hA001);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_pop", bus.word, 16'hA000 + 16'(k));
      step(4'h0, 1'b0, 1'b1);
    end
    chk("ovf_empty", 16'(bus.level), 16'h0);
    chk("ovf_stick", 16'(bus.ovf), 16'h1);

    // simultaneous push and pop while full
    step(4'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      send_word(16'hC000 + 16'(k), 1'b0);
    end
    step(4'hB, 1'b1, 1'b0);
    step(4'hE, 1'b1, 1'b0);
    step(4'hE, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b1);
    chk("pp_lvl", 16'(bus.level), 16'h4);
    chk("pp_ovf", 16'(bus.ovf), 16'h0);
    chk("pp_head", bus.word, 16'hC002);
    for (int k = 0; k < 3; k++) step(4'h0, 1'b0, 1'b1);
    chk("pp_tail", bus.word, 16'hBEEF);
    step(4'h0, 1'b0, 1'b1);

    // gaps inside a word
    step(4'h9, 1'b1, 1'b0);
    step(4'hC, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(4'h0, 1'b0, 1'b0);
    step(4'h6, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    chk("gap_word", bus.word, 16'h9C60);
    chk("gap_tmo", 16'(bus.tmo), 16'h0);

    // reset mid-word discards it
    step(4'h3, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0, 1'b1);
    chk("mid_rst", 16'(bus.level), 16'h0);
    send_word(16'hFEDC, 1'b0);
    chk("fedc", bus.word, 16'hFEDC);
    step(4'h0, 1'b0, 1'b1);

`ifdef NIBBLE_TIMEOUT_EN
    // timeout of a one-nibble partial word
    begin
      int pulses = 0;
      step(4'h7, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) begin
        step(4'h0, 1'b0, 1'b0);
        if (bus.tmo === 1'b1) pulses++;
      end
      chk("tmo_cnt", 16'(pulses), 16'h1);
      send_word(16'h1111, 1'b0);
      chk("w1111", bus.word, 16'h1111);
      step(4'h0, 1'b0, 1'b1);
    end
`endif

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic v;
      logic r;
      logic rs;
      if ((k / 100) % 2 == 1) v = ($urandom_range(0, 5) == 0);
      else v = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(4'($urandom), v, r, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
